// File: rtl/vga_fetch_pkg.sv
// Shared constants and state type for the VGA framebuffer fetch block.
package vga_fetch_pkg;
   localparam int SRAM_AW      = 20;
   localparam int SRAM_DW      = 48;
   localparam int FLUSH_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      FETCH = 2'd2
   } state_e;
endpackage

// File: rtl/vga_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module fetch_fifo #(
   parameter int DW = 48,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);
   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push_s, do_pop_s;

   // A flush wins over any push or pop in the same cycle.
   always_comb begin
      do_push_s = push && !flush && (count_q != DEPTH);
      do_pop_s  = pop && !flush && (count_q != '0);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH);
   assign count = count_q;
endmodule

// File: rtl/vga_fetch.sv
// VGA client of the SRAM arbiter: sequential frame reads into a FWFT FIFO.
// Define VGA_FETCH_STATS_EN to add the stall_cnt and words_fetched outputs.
module vga_fetch
   import vga_fetch_pkg::*;
#(
   parameter logic [SRAM_AW-1:0] FRAME_BASE  = 20'h00000,
   parameter logic [SRAM_AW-1:0] FRAME_WORDS = 20'd76800,
   parameter int                 FIFO_AW     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_sel,
   input  logic [SRAM_DW-1:0] sram_data,
   input  logic               sram_valid,
   output logic [SRAM_DW-1:0] pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               underflow
`ifdef VGA_FETCH_STATS_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [SRAM_AW-1:0] words_fetched
`endif
);
   localparam int                  FLUSH_CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FLUSH_CW-1:0] FLUSH_LAST = FLUSH_CW'(FLUSH_CYCLES - 1);
   localparam logic [FIFO_AW:0]    FIFO_DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

   state_e              state_q, state_d;
   logic [FLUSH_CW-1:0] flush_cnt_q, flush_cnt_d;
   logic [SRAM_AW-1:0]  addr_q, addr_d;
   logic [SRAM_AW-1:0]  wcnt_q, wcnt_d;
   logic                underflow_q, underflow_d;
   logic                sel_s, capture_s, push_s, pop_s;
   logic                fifo_empty_s, fifo_full_s;
   logic [FIFO_AW:0]    fifo_count_s;
`ifdef VGA_FETCH_STATS_EN
   logic [15:0]         stall_q, stall_d;
`endif

   always_comb begin
      sel_s       = (state_q == FETCH) && !fifo_full_s;
      capture_s   = sel_s && sram_valid;
      push_s      = capture_s && !frame_start && (fifo_count_s != FIFO_DEPTH);
      pop_s       = pix_ready && !fifo_empty_s;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      addr_d      = addr_q;
      wcnt_d      = wcnt_q;
      underflow_d = underflow_q;
`ifdef VGA_FETCH_STATS_EN
      stall_d     = stall_q;
`endif
      // frame_start overrides everything, including a capture in flight.
      if (frame_start) begin
         state_d     = FLUSH;
         flush_cnt_d = '0;
         addr_d      = FRAME_BASE;
         wcnt_d      = '0;
         underflow_d = 1'b0;
`ifdef VGA_FETCH_STATS_EN
         stall_d     = 16'h0000;
`endif
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            FLUSH: begin
               if (flush_cnt_q == FLUSH_LAST) state_d = FETCH;
               else flush_cnt_d = flush_cnt_q + FLUSH_CW'(1);
            end
            FETCH: begin
               if (capture_s) begin
                  addr_d = addr_q + 20'd1;
                  wcnt_d = wcnt_q + 20'd1;
                  if (wcnt_q == FRAME_WORDS - 20'd1) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         if (pix_ready && fifo_empty_s && (state_q != IDLE)) underflow_d = 1'b1;
`ifdef VGA_FETCH_STATS_EN
         if (sel_s && !sram_valid && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         addr_q      <= '0;
         wcnt_q      <= '0;
         underflow_q <= 1'b0;
`ifdef VGA_FETCH_STATS_EN
         stall_q     <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         addr_q      <= addr_d;
         wcnt_q      <= wcnt_d;
         underflow_q <= underflow_d;
`ifdef VGA_FETCH_STATS_EN
         stall_q     <= stall_d;
`endif
      end
   end

   fetch_fifo #(
      .DW (SRAM_DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (frame_start),
      .push  (push_s),
      .pop   (pop_s),
      .din   (sram_data),
      .dout  (pix_data),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   assign sram_sel  = sel_s;
   assign sram_addr = addr_q;
   assign pix_valid = !fifo_empty_s;
   assign underflow = underflow_q;
`ifdef VGA_FETCH_STATS_EN
   assign stall_cnt     = stall_q;
   assign words_fetched = wcnt_q;
`endif
endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch: scenario table plus hand-written restart sequences.
`timescale 1ns/1ps
module tb_vga_fetch;
   localparam logic [19:0] BASE   = 20'h100;
   localparam int          NWORDS = 24;
   localparam int          DEPTH  = 16;
   localparam int          NFLUSH = 2;

   logic        clk = 1'b0;
   logic        rst, frame_start, sram_sel, sram_valid, pix_valid, pix_ready, underflow;
   logic [19:0] sram_addr;
   logic [47:0] sram_data, pix_data;
`ifdef VGA_FETCH_STATS_EN
   logic [15:0] stall_cnt;
   logic [19:0] words_fetched;
`endif

   always #5 clk = ~clk;

   vga_fetch #(
      .FRAME_BASE  (BASE),
      .FRAME_WORDS (20'(NWORDS)),
      .FIFO_AW     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .sram_addr   (sram_addr),
      .sram_sel    (sram_sel),
      .sram_data   (sram_data),
      .sram_valid  (sram_valid),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .underflow   (underflow)
`ifdef VGA_FETCH_STATS_EN
      ,
      .stall_cnt     (stall_cnt),
      .words_fetched (words_fetched)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: words captured / popped since frame start, frame activity, flags.
   bit active     = 1'b0;
   int flush_left = 0;
   int caps       = 0;
   int pops       = 0;
   bit m_uf       = 1'b0;
   int m_stall    = 0;

   // Arbiter and consumer models.
   int          cur_lat     = 1;
   bit          rand_lat    = 1'b0;
   int          ready_mode  = 0;
   bit          force_valid = 1'b0;
   int          hold        = 0;
   logic        prev_sel    = 1'b0;
   logic [19:0] prev_addr   = 20'h0;

   typedef struct {
      int lat;
      bit rnd;
      int ready;
      int exp_uf;
      int exp_stall;
   } scen_t;
   scen_t scen [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      sram_valid = !rst && (force_valid || (sram_sel === 1'b1 && hold >= cur_lat));
      sram_data  = {28'h0, sram_addr};
      case (ready_mode)
         0:       pix_ready = 1'b0;
         1:       pix_ready = 1'b1;
         2:       pix_ready = (pix_valid === 1'b1);
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic tick();
      int          occ;
      bit          exp_sel;
      logic [19:0] exp_addr;
      occ      = caps - pops;
      exp_sel  = active && (flush_left == 0) && (occ < DEPTH);
      exp_addr = BASE + 20'(caps);
      if (!rst) begin
         check("sram_sel", 64'(sram_sel), 64'(exp_sel));
         check("pix_valid", 64'(pix_valid), 64'(occ != 0));
         check("underflow", 64'(underflow), 64'(m_uf));
         if (exp_sel) check("sram_addr", 64'(sram_addr), 64'(exp_addr));
      end
      if (rst) begin
         active = 1'b0; flush_left = 0; caps = 0; pops = 0; m_uf = 1'b0; m_stall = 0;
      end else if (frame_start) begin
         active = 1'b1; flush_left = NFLUSH; caps = 0; pops = 0; m_uf = 1'b0; m_stall = 0;
      end else begin
         if (pix_ready && occ == 0 && active) m_uf = 1'b1;
         if (pix_ready && occ > 0) begin
            check("pix_data", 64'(pix_data), 64'({28'h0, BASE + 20'(pops)}));
            pops++;
         end
         if (exp_sel && !sram_valid && m_stall < 65535) m_stall++;
         if (exp_sel && sram_valid) begin
            caps++;
            if (caps == NWORDS) active = 1'b0;
         end
         if (flush_left > 0) flush_left--;
      end
      @(posedge clk);
      #1;
      if (sram_sel === 1'b1) begin
         if (prev_sel === 1'b1 && sram_addr == prev_addr) hold++;
         else begin
            hold = 0;
            if (rand_lat) cur_lat = $urandom_range(0, 3);
         end
      end else begin
         hold = 0;
      end
      prev_sel  = sram_sel;
      prev_addr = sram_addr;
      apply();
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic run_frame();
      for (int c = 0; c < 4000; c++) begin
         if (caps == NWORDS && pops == NWORDS) break;
         tick();
      end
      check("frame_done", 64'(caps == NWORDS && pops == NWORDS), 64'd1);
   endtask

   task automatic end_checks(input int exp_uf, input int exp_stall);
      repeat (5) tick();
      check("idle_sel", 64'(sram_sel), 64'd0);
      check("idle_pix_valid", 64'(pix_valid), 64'd0);
      if (exp_uf >= 0) check("end_underflow", 64'(underflow), 64'(exp_uf));
`ifdef VGA_FETCH_STATS_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (exp_stall >= 0) check("stall_cnt_abs", 64'(stall_cnt), 64'(exp_stall));
      check("words_fetched", 64'(words_fetched), 64'(NWORDS));
`else
      if (exp_stall < -1) check("stall_arg", 64'(exp_stall), 64'(m_stall));
`endif
   endtask

   initial begin
      scen[0] = '{lat: 1, rnd: 1'b0, ready: 2, exp_uf: 0,  exp_stall: NWORDS};
      scen[1] = '{lat: 5, rnd: 1'b0, ready: 1, exp_uf: 1,  exp_stall: 5 * NWORDS};
      scen[2] = '{lat: 0, rnd: 1'b0, ready: 2, exp_uf: 0,  exp_stall: 0};
      scen[3] = '{lat: 0, rnd: 1'b1, ready: 3, exp_uf: -1, exp_stall: -1};
      scen[4] = '{lat: 0, rnd: 1'b1, ready: 2, exp_uf: 0,  exp_stall: -1};

      rst = 1'b1; frame_start = 1'b0; pix_ready = 1'b0; sram_valid = 1'b0; sram_data = 48'h0;
      repeat (3) tick();
      check("rst_sel", 64'(sram_sel), 64'd0);
      check("rst_addr", 64'(sram_addr), 64'd0);
      check("rst_pix_valid", 64'(pix_valid), 64'd0);
      check("rst_underflow", 64'(underflow), 64'd0);
      rst = 1'b0;
      apply();
      repeat (20) tick();
      check("idle_no_sel", 64'(sram_sel), 64'd0);

      for (int i = 0; i < 5; i++) begin
         cur_lat = scen[i].lat; rand_lat = scen[i].rnd; ready_mode = scen[i].ready;
         apply();
         start_frame();
         check("uf_cleared", 64'(underflow), 64'd0);
         run_frame();
         end_checks(scen[i].exp_uf, scen[i].exp_stall);
      end

      // Back-pressure: FIFO fills to 16, sel drops, then resumes at BASE+16.
      cur_lat = 1; rand_lat = 1'b0; ready_mode = 0;
      apply();
      start_frame();
      repeat (100) tick();
      check("bp_caps", 64'(caps), 64'd16);
      check("bp_sel_low", 64'(sram_sel), 64'd0);
      check("bp_pix_valid", 64'(pix_valid), 64'd1);
      check("bp_addr", 64'(sram_addr), 64'(BASE + 20'd16));
      ready_mode = 2;
      apply();
      run_frame();
      end_checks(0, -1);

      // Mid-frame restart with a request pending and stale valids during FLUSH.
      cur_lat = 2; ready_mode = 0;
      apply();
      start_frame();
      for (int c = 0; c < 200 && caps < 5; c++) tick();
      check("rs_caps", 64'(caps), 64'd5);
      check("rs_pending_sel", 64'(sram_sel), 64'd1);
      check("rs_pending_addr", 64'(sram_addr), 64'(BASE + 20'd5));
      force_valid = 1'b1;
      start_frame();
      check("rs_pv_flushed", 64'(pix_valid), 64'd0);
      check("rs_flush1_sel", 64'(sram_sel), 64'd0);
      tick();
      check("rs_flush2_sel", 64'(sram_sel), 64'd0);
      force_valid = 1'b0;
      apply();
      tick();
      check("rs_fetch_sel", 64'(sram_sel), 64'd1);
      check("rs_fetch_addr", 64'(sram_addr), 64'(BASE));
      check("rs_no_stale_push", 64'(pix_valid), 64'd0);
      ready_mode = 2;
      apply();
      run_frame();
      end_checks(0, -1);

      // Reset in the middle of a frame drops FIFO contents.
      cur_lat = 1; ready_mode = 0;
      apply();
      start_frame();
      repeat (30) tick();
      check("mid_fifo_nonempty", 64'(pix_valid), 64'd1);
      rst = 1'b1;
      frame_start = 1'b1;
      tick();
      rst = 1'b0;
      frame_start = 1'b0;
      apply();
      check("mid_rst_pv", 64'(pix_valid), 64'd0);
      check("mid_rst_sel", 64'(sram_sel), 64'd0);
      check("mid_rst_addr", 64'(sram_addr), 64'd0);
      check("mid_rst_uf", 64'(underflow), 64'd0);
      repeat (10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
